// File: rtl/caesar_ctxt_packer.sv
// Packs accepted Caesar ciphertext characters little-endian into 32-bit words,
// drops characters flagged by the cipher core, and queues words in a show-ahead FIFO.
module caesar_ctxt_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ctxt_valid,
    input  logic             ctxt_last,
    input  logic [7:0]       ctxt_char,
    input  logic             err_invalid_key_shift_num,
    input  logic             err_invalid_ptxt_char,
    output logic             ctxt_ready,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [31:0]      word_data,
    output logic [2:0]       word_bytes,
    output logic             word_last,
    output logic             overflow_err,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] char_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      fifo_data_q  [FIFO_DEPTH];
    logic [2:0]       fifo_bytes_q [FIFO_DEPTH];
    logic             fifo_last_q  [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [31:0]      pack_q, pack_d, pack_new;
    logic [1:0]       idx_q, idx_d;
    logic             overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d, char_cnt_q, char_cnt_d;

    logic             accept, flagged, push, pop;
    logic [31:0]      push_data;
    logic [2:0]       push_bytes;
    logic             push_last;

    assign ctxt_ready = (occ_q < OCC_W'(FIFO_DEPTH));
    assign accept     = ctxt_valid && ctxt_ready;
    assign flagged    = err_invalid_key_shift_num || err_invalid_ptxt_char;
    assign pack_new   = pack_q | ({24'h0, ctxt_char} << {idx_q, 3'b000});

    assign word_valid   = (occ_q != '0);
    assign pop          = word_valid && word_ready;
    assign word_data    = word_valid ? fifo_data_q[rd_ptr_q]  : 32'h0;
    assign word_bytes   = word_valid ? fifo_bytes_q[rd_ptr_q] : 3'd0;
    assign word_last    = word_valid ? fifo_last_q[rd_ptr_q]  : 1'b0;
    assign drop_cnt     = drop_cnt_q;
    assign char_cnt     = char_cnt_q;

    always_comb begin
        pack_d     = pack_q;
        idx_d      = idx_q;
        overflow_d = overflow_err;
        drop_cnt_d = drop_cnt_q;
        char_cnt_d = char_cnt_q;
        push       = 1'b0;
        push_data  = 32'h0;
        push_bytes = 3'd0;
        push_last  = 1'b0;
        if (clr) begin
            pack_d     = 32'h0;
            idx_d      = 2'd0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            char_cnt_d = '0;
        end else begin
            if (ctxt_valid && !ctxt_ready) overflow_d = 1'b1;
            if (accept && flagged) begin
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
                // A flagged last character still closes the message, possibly with an empty word.
                if (ctxt_last) begin
                    push       = 1'b1;
                    push_data  = pack_q;
                    push_bytes = {1'b0, idx_q};
                    push_last  = 1'b1;
                    pack_d     = 32'h0;
                    idx_d      = 2'd0;
                end
            end else if (accept) begin
                if (char_cnt_q != '1) char_cnt_d = char_cnt_q + CNT_W'(1);
                if (idx_q == 2'd3 || ctxt_last) begin
                    push       = 1'b1;
                    push_data  = pack_new;
                    push_bytes = {1'b0, idx_q} + 3'd1;
                    push_last  = ctxt_last;
                    pack_d     = 32'h0;
                    idx_d      = 2'd0;
                end else begin
                    pack_d = pack_new;
                    idx_d  = idx_q + 2'd1;
                end
            end
        end
    end

    always_comb begin
        occ_d = occ_q;
        if (push && !pop)      occ_d = occ_q + OCC_W'(1);
        else if (!push && pop) occ_d = occ_q - OCC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            pack_q       <= 32'h0;
            idx_q        <= 2'd0;
            overflow_err <= 1'b0;
            drop_cnt_q   <= '0;
            char_cnt_q   <= '0;
        end else begin
            occ_q        <= occ_d;
            pack_q       <= pack_d;
            idx_q        <= idx_d;
            overflow_err <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            char_cnt_q   <= char_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset; outputs are masked by word_valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_data_q[wr_ptr_q]  <= push_data;
            fifo_bytes_q[wr_ptr_q] <= push_bytes;
            fifo_last_q[wr_ptr_q]  <= push_last;
        end
    end

endmodule

// File: doc/caesar_ctxt_packer.md
Name: caesar_ctxt_packer

Overview:
- Downstream stage of the Caesar cipher core. Consumes its registered ciphertext stream of one character per cycle, together with its registered error flags.
- Discards characters the core flagged as invalid.
- Packs valid characters little-endian into 32-bit words and buffers them in a small FIFO.
- Presents the words on a valid/ready interface to the message/hash datapath, which sees clean 32-bit words and never NULL_CHAR filler from rejected characters.

Parameters:
FIFO_DEPTH, 4, number of 32-bit word entries in the output FIFO (power of 2, >=2)
CNT_W, 16, width of the dropped-character and accepted-character counters

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
clr  input  1  synchronous clear of counters, sticky overflow flag and partial pack register (FIFO contents kept)
ctxt_valid  input  1  ctxt_char/flags below carry a character this cycle (upstream control aligned to cipher output)
ctxt_last  input  1  qualifies ctxt_valid: final character of a message
ctxt_char  input  8  ciphertext character from cipher core
err_invalid_key_shift_num  input  1  registered cipher flag, aligned with ctxt_char
err_invalid_ptxt_char  input  1  registered cipher flag, aligned with ctxt_char
ctxt_ready  output  1  block can accept a character this cycle
word_valid  output  1  word_data holds a FIFO head entry
word_ready  input  1  consumer accepts head entry when word_valid && word_ready
word_data  output  32  packed characters, first character in [7:0]
word_bytes  output  3  number of valid bytes in word_data, 0..4
word_last  output  1  word terminates a message
overflow_err  output  1  sticky: character presented while ctxt_ready low
drop_cnt  output  CNT_W  saturating count of characters dropped due to cipher error flags
char_cnt  output  CNT_W  saturating count of characters packed

Behaviour:
- Reset (rst_n low at clk edge):
  - FIFO is emptied; pack register, byte index and counters are zeroed.
  - word_valid, word_data, word_bytes, word_last, overflow_err are 0; ctxt_ready is 1 from the first cycle after reset.
  - Reset mid-message discards partial pack and FIFO contents with no flush.
- ctxt_ready = (FIFO occupancy < FIFO_DEPTH). It is combinational from registered occupancy and is independent of word_ready in the same cycle.
- Accept = ctxt_valid && ctxt_ready.
- ctxt_valid && !ctxt_ready:
  - The character is discarded and overflow_err is set (sticky until clr/reset).
  - No counter, pack or FIFO change.
- Accepted character with either error flag high:
  - Not packed; drop_cnt += 1 (saturate at all-ones).
  - If ctxt_last is set, the current partial pack is flushed as below, even when it has 0 bytes: a word with word_bytes=0, word_data=0 and word_last=1 is pushed.
- Accepted valid character:
  - Written to byte lane idx of the pack register; idx += 1; char_cnt += 1 (saturating).
  - If idx was 3 or ctxt_last=1, push {pack with new byte, bytes=idx+1, last=ctxt_last} into the FIFO and reset idx to 0.
  - Unused upper lanes of a pushed word are 8'h00.
- FIFO:
  - Show-ahead; a word pushed at edge t is visible with word_valid=1 after edge t, i.e. one cycle of latency from the completing character.
  - Pop on word_valid && word_ready.
  - Simultaneous push and pop: occupancy unchanged and both take effect.
  - Push only occurs when not full, guaranteed by ctxt_ready.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- word_valid/word_data/word_bytes/word_last hold stable while word_valid && !word_ready.
- clr:
  - Zeroes drop_cnt, char_cnt, overflow_err, idx and pack register.
  - A character accepted in the same cycle as clr is ignored.
  - FIFO is untouched.
- Precedence: rst_n > clr > accept.

Test Plan:
- Reset then 8 valid chars 'H','E','L','L','O','W','O','R' with word_ready=1, last on 'R' -> two words 32'h4C4C4548 (bytes=4, last=0), 32'h524F574F (bytes=4, last=1), each valid one cycle after its 4th char; char_cnt=8.
- Chars 'A','B' then 'C' with ctxt_last=1 -> single word 32'h00434241, bytes=3, last=1.
- 'X' valid, then 'Y' with err_invalid_ptxt_char=1 and ctxt_last=1 -> word 32'h00000058 bytes=1 last=1; drop_cnt=1; lone flagged char with last -> word 0, bytes=0, last=1.
- word_ready=0, stream 4*FIFO_DEPTH=16 valid chars -> ctxt_ready drops after the 16th accepted char; a 17th char presented sets overflow_err=1 while occupancy stays 4; raising word_ready drains the 4 words in order, data unchanged while stalled.
- FIFO at 3 entries, push and pop in same cycle -> occupancy stays 3, ctxt_ready stays 1, order preserved across pointer wrap.
- Two chars packed, then clr=1 with ctxt_valid=1 -> idx=0, counters 0, overflow_err 0, char ignored; rst_n=0 mid-message -> word_valid=0 next cycle, ctxt_ready=1.
